// File: rtl/tile_config_mem_rb.sv
// Tile configuration memory with readback.
// Frames are captured from the column FrameData/FrameStrobe bus on strobe rising
// edges and drive ConfigBits/ConfigBits_N into the tile. A sticky lock, frame
// coverage tracking, strobe error detection and a ready/valid readback port
// are included.
//
// Readback FSM states:
//   state | meaning
//   IDLE  | RbReady high, waiting for RbReq
//   RESP  | RbValid high, RbData/RbErr held until RbAck
module tile_config_mem_rb #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 600,
    parameter int FrameIdxWidth   = 5
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic                       Lock,
    input  logic                       RbReq,
    input  logic [FrameIdxWidth-1:0]   RbFrame,
    output logic                       RbReady,
    output logic                       RbValid,
    input  logic                       RbAck,
    output logic [FrameBitsPerRow-1:0] RbData,
    output logic                       RbErr,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N,
    output logic                       ConfigValid,
    output logic                       StrobeErr,
    output logic                       WriteBlocked
);

    localparam int NF    = (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow;
    localparam int TOTAL = MaxFramesPerCol * FrameBitsPerRow;
    // Bits at or above NoConfigBits are never stored, so unused frames and the
    // top of the last used frame always read back as zero.
    localparam logic [TOTAL-1:0] USED_MASK = {TOTAL{1'b1}} >> (TOTAL - NoConfigBits);

    typedef enum logic [0:0] {IDLE, RESP} rb_state_t;

    logic [TOTAL-1:0]           cfg_q;
    logic [MaxFramesPerCol-1:0] strobe_q;
    logic [MaxFramesPerCol-1:0] rise;
    logic [MaxFramesPerCol-1:0] wr_en;
    logic [NF-1:0]              written_q;
    logic [NF-1:0]              written_d;
    logic                       lock_q;
    logic                       one_hot;
    logic                       multi_hot;
    logic                       config_valid_q;
    logic                       strobe_err_q;
    logic                       write_blocked_q;
    logic [FrameBitsPerRow-1:0] rb_sel;
    logic                       rb_oor;
    rb_state_t                  state_q;
    logic                       rb_ready_q;
    logic                       rb_valid_q;
    logic [FrameBitsPerRow-1:0] rb_data_q;
    logic                       rb_err_q;

    // Strobe edge classification, write enables and readback frame select.
    always_comb begin
        rise      = FrameStrobe & ~strobe_q;
        one_hot   = $onehot(rise);
        multi_hot = (rise != '0) && !one_hot;
        // The lock state from before the edge gates the write, so a Lock
        // arriving with a write still lets that write through.
        wr_en     = (one_hot && !lock_q) ? rise : '0;
        written_d = written_q | wr_en[NF-1:0];
        rb_oor    = (32'(RbFrame) >= MaxFramesPerCol);
        rb_sel    = '0;
        for (int f = 0; f < MaxFramesPerCol; f++) begin
            if (RbFrame == FrameIdxWidth'(f)) begin
                rb_sel = cfg_q[f*FrameBitsPerRow +: FrameBitsPerRow];
            end
        end
    end

    // Frame storage: one accepted write per rising strobe edge, used frames only.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            cfg_q <= '0;
        end else begin
            for (int f = 0; f < NF; f++) begin
                if (wr_en[f]) begin
                    cfg_q[f*FrameBitsPerRow +: FrameBitsPerRow] <=
                        FrameData & USED_MASK[f*FrameBitsPerRow +: FrameBitsPerRow];
                end
            end
        end
    end

    // Strobe history, sticky lock, coverage and sticky error flags.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            strobe_q        <= '0;
            lock_q          <= 1'b0;
            written_q       <= '0;
            config_valid_q  <= 1'b0;
            strobe_err_q    <= 1'b0;
            write_blocked_q <= 1'b0;
        end else begin
            strobe_q        <= FrameStrobe;
            lock_q          <= lock_q | Lock;
            written_q       <= written_d;
            config_valid_q  <= &written_d;
            strobe_err_q    <= strobe_err_q | multi_hot;
            write_blocked_q <= write_blocked_q | (one_hot & lock_q);
        end
    end

    // Readback FSM; captures pre-edge frame contents so a same-edge write returns old data.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rb_ready_q <= 1'b1;
            rb_valid_q <= 1'b0;
            rb_data_q  <= '0;
            rb_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (RbReq) begin
                        rb_data_q  <= rb_oor ? '0 : rb_sel;
                        rb_err_q   <= rb_oor;
                        rb_ready_q <= 1'b0;
                        rb_valid_q <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (RbAck) begin
                        rb_ready_q <= 1'b1;
                        rb_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    rb_ready_q <= 1'b1;
                    rb_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign ConfigBits   = cfg_q[NoConfigBits-1:0];
    assign ConfigBits_N = ~cfg_q[NoConfigBits-1:0];
    assign ConfigValid  = config_valid_q;
    assign StrobeErr    = strobe_err_q;
    assign WriteBlocked = write_blocked_q;
    assign RbReady      = rb_ready_q;
    assign RbValid      = rb_valid_q;
    assign RbData       = rb_data_q;
    assign RbErr        = rb_err_q;

endmodule

// File: doc/tile_config_mem_rb.md
Name: tile_config_mem_rb

Overview:
Clocked, parametrised tile configuration memory with readback. It is the successor to the latch-based per-tile ConfigMem. The block captures frames from the column FrameData/FrameStrobe bus on strobe rising edges and drives ConfigBits/ConfigBits_N into the tile switch matrix and BELs. It adds lock protection, frame-coverage tracking, strobe error detection, and a ready/valid readback port for bitstream verification by the configuration FSM.

Parameters:
MaxFramesPerCol, 20, number of frames (strobe lines) per column.
FrameBitsPerRow, 32, bits per frame (FrameData width).
NoConfigBits, 600, config bits used by the tile. Legal range is 1..MaxFramesPerCol*FrameBitsPerRow.
FrameIdxWidth, 5, readback index width. Must satisfy 2^FrameIdxWidth >= MaxFramesPerCol.

Ports:
CLK  in  1  configuration clock; all state updates on rising edge.
resetn  in  1  synchronous active-low reset.
FrameData  in  FrameBitsPerRow  frame payload.
FrameStrobe  in  MaxFramesPerCol  per-frame strobe, nominally one-hot.
Lock  in  1  when sampled high, sets the sticky lock; cleared only by reset.
RbReq  in  1  readback request valid.
RbFrame  in  FrameIdxWidth  readback frame index.
RbReady  out  1  readback request ready.
RbValid  out  1  readback response valid.
RbAck  in  1  readback response accepted.
RbData  out  FrameBitsPerRow  readback frame contents.
RbErr  out  1  readback index out of range; qualified by RbValid.
ConfigBits  out  NoConfigBits  configuration bits.
ConfigBits_N  out  NoConfigBits  bitwise inverse of ConfigBits.
ConfigValid  out  1  every used frame has been written at least once since reset.
StrobeErr  out  1  sticky; multi-hot strobe rising edge detected.
WriteBlocked  out  1  sticky; a write was attempted while locked.

Behaviour:
- Storage: frame[f] registers, FrameBitsPerRow wide. ConfigBits[k] = frame[k / FrameBitsPerRow][k % FrameBitsPerRow]. ConfigBits_N = ~ConfigBits. Both are combinational from the frame registers.
- Used frames: NF = ceil(NoConfigBits / FrameBitsPerRow). Frames with index >= NF are never written and always read as 0. Bits of frame NF-1 above the used range are masked to 0 on write.
- Edge detect: strobe_q <= FrameStrobe every cycle. rise = FrameStrobe & ~strobe_q.
- Write rules:
  - If rise is exactly one-hot (bit f), the frame is in use, and the block is unlocked: frame[f] <= masked FrameData on that same edge. ConfigBits updates immediately after that edge, so latency is 1 edge.
  - If rise has 2 or more bits set: no frame is written and StrobeErr is set.
  - If rise is one-hot but the block is locked: no write and WriteBlocked is set.
  - A strobe held high writes only once.
- Lock is sampled every edge. The write decision uses the lock state before the edge, so a Lock rising on the same edge as a write still allows that write.
- Coverage: written[f] sets on each accepted write. ConfigValid = AND of written[0..NF-1], registered.
- Readback FSM:
  - IDLE: RbReady=1, RbValid=0. On RbReq&RbReady, capture RbData = frame[RbFrame] using pre-edge contents, so a same-edge write returns the old value. RbErr = (RbFrame >= MaxFramesPerCol), and RbData = 0 when RbErr is set. Go to RESP.
  - RESP: RbReady=0, RbValid=1. RbData and RbErr are held stable. On RbAck go to IDLE; the next request can be accepted on the following edge.
  - Readback never blocks writes.
- Reset (resetn=0 at an edge) applies to all state, including mid-readback:
  - frames=0, so ConfigBits=0 and ConfigBits_N=all 1s.
  - strobe_q=0, written=0, lock=0.
  - ConfigValid, StrobeErr, WriteBlocked = 0.
  - FSM in IDLE: RbReady=1 after reset, RbValid=0, RbData=0, RbErr=0.
  - Caveat: because strobe_q clears, a strobe held high across reset is seen as a rising edge on the first edge after reset.

Test Plan:
1. Reset, then pulse FrameStrobe=1<<3 for 1 cycle with FrameData=32'hA5A5_0F0F → ConfigBits[127:96]=32'hA5A5_0F0F on the next cycle; ConfigBits_N[127:96]=32'h5A5A_F0F0; other bits unchanged.
2. Write frame 18 with 32'hFFFF_FFFF → only ConfigBits[599:576]=24'hFFFFFF. Readback of frame 18 returns 32'h00FF_FFFF. Readback of frame 19 returns 0 with RbErr=0. Readback of RbFrame=25 returns RbErr=1, RbData=0.
3. Write frames 0..18 once each → ConfigValid=1 after the last write. Skip frame 7 instead → ConfigValid stays 0.
4. FrameStrobe=20'h00003 rising → no frame changes, StrobeErr=1. Hold FrameStrobe=1<<2 high for 5 cycles while changing FrameData → only the first-cycle value is stored.
5. Assert Lock, then write frame 4 with 32'h1234_5678 → frame 4 unchanged, WriteBlocked=1. Assert resetn=0 → all flags clear and ConfigBits=0.
6. In the same cycle, issue RbReq for frame 5 and a strobe write of 32'hDEAD_BEEF to frame 5 (old value 32'h1111_1111) → RbData=32'h1111_1111 held until RbAck. A second readback returns 32'hDEAD_BEEF. RbReady=0 while RbValid=1.
